aes_out_serializer: RTL and testbench

Downstream stage of the pipelined AES-128 core (`AES_top`). `AES_top` has no valid signal, so this block tracks which of its result cycles carry real blocks and captures each 128-bit `cryptokey` result into a small FIFO. It then streams each block out as four 32-bit words over a valid/ready handshake to the bus-side consumer.

---
 rtl/aes_pkg.sv | 33 +++
 rtl/aes_out_serializer_if.sv | 24 ++
 rtl/aes_block_fifo.sv | 63 ++++++
 rtl/aes_out_serializer.sv | 131 +++++++++++++
 tb/tb_aes_out_serializer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES result serializer.
package aes_pkg;

   localparam int AES_BLOCK_W         = 128;
   localparam int AES_WORD_W          = 32;
   localparam int AES_WORDS_PER_BLOCK = 4;
   localparam int WORD_IDX_W          = $clog2(AES_WORDS_PER_BLOCK);

   typedef logic [WORD_IDX_W-1:0] word_idx_t;

   localparam word_idx_t LAST_WORD_IDX = word_idx_t'(AES_WORDS_PER_BLOCK - 1);

   typedef enum logic {
      IDLE,
      SEND
   } ser_state_t;

   // Word 0 is the most significant 32 bits of the block.
   function automatic logic [AES_WORD_W-1:0] block_word(
      input logic [AES_BLOCK_W-1:0] blk,
      input word_idx_t              idx
   );
      logic [AES_WORD_W-1:0] w;
      case (idx)
         2'd0:    w = blk[127:96];
         2'd1:    w = blk[95:64];
         2'd2:    w = blk[63:32];
         default: w = blk[31:0];
      endcase
      return w;
   endfunction

endpackage

// File: rtl/aes_out_serializer_if.sv
// Word stream handshake between the serializer and the bus-side consumer.
interface aes_out_serializer_if;
   import aes_pkg::*;

   logic                  m_valid;
   logic                  m_ready;
   logic [AES_WORD_W-1:0] m_data;
   logic                  m_last;

   modport master (
      output m_valid,
      output m_data,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      input  m_last,
      output m_ready
   );

endinterface

// File: rtl/aes_block_fifo.sv
// Synchronous FIFO of whole 128-bit result blocks. A push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module aes_block_fifo
   import aes_pkg::*;
#(
   parameter  int FIFO_DEPTH = 4,
   localparam int PTR_W      = $clog2(FIFO_DEPTH),
   localparam int LEVEL_W    = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [AES_BLOCK_W-1:0] wdata,
   output logic                   full,
   output logic                   empty,
   output logic [LEVEL_W-1:0]     level,
   output logic [AES_BLOCK_W-1:0] head
);

   logic [AES_BLOCK_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [LEVEL_W-1:0]     count;
   logic                   do_push;
   logic                   do_pop;

   assign full    = (count == LEVEL_W'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign level   = count;
   assign head    = mem[rd_ptr];

   // Block storage; contents are only meaningful below the level count.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap by natural overflow; count tracks occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + LEVEL_W'(1);
            2'b01:   count <= count - LEVEL_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/aes_out_serializer.sv
// Tracks which AES_top result cycles carry real blocks, buffers those
// results and streams each one out as four 32-bit words, MSW first.
module aes_out_serializer
   import aes_pkg::*;
#(
   parameter  int LATENCY    = 10,
   parameter  int FIFO_DEPTH = 4,
   localparam int LEVEL_W    = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_start,
   input  logic [AES_BLOCK_W-1:0]   cryptokey_in,
   aes_out_serializer_if.master     bus,
   output logic [LEVEL_W-1:0]       level,
   output logic                     overflow
);

   logic [LATENCY-1:0]     track;
   logic                   tap;
   logic                   push;
   logic                   pop;
   logic                   drop;
   logic                   full;
   logic                   empty;
   logic [AES_BLOCK_W-1:0] head;
   ser_state_t             state;
   ser_state_t             state_nxt;
   word_idx_t              idx;
   word_idx_t              idx_nxt;

   // The tracker's last stage is high exactly when cryptokey_in is valid.
   generate
      if (LATENCY == 1) begin : g_track_single
         // One-stage tracker: delay in_start by a single cycle.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               track <= '0;
            end else begin
               track <= in_start;
            end
         end
      end else begin : g_track_shift
         // Multi-stage tracker: shift in_start along LATENCY stages.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               track <= '0;
            end else begin
               track <= {track[LATENCY-2:0], in_start};
            end
         end
      end
   endgenerate

   assign tap  = track[LATENCY-1];

   // The head leaves the FIFO when its last word is accepted.
   assign pop  = (state == SEND) && bus.m_ready && (idx == LAST_WORD_IDX);

   // A full FIFO still takes a result if the head leaves in the same cycle.
   assign push = tap && (!full || pop);
   assign drop = tap && !push;

   aes_block_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (cryptokey_in),
      .full  (full),
      .empty (empty),
      .level (level),
      .head  (head)
   );

   // Sticky record that at least one result was lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end
   end

   // FSM state and word index registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // Next-state logic and word mux. IDLE also looks at the push itself so
   // that SEND is entered on the same edge the first block is written.
   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      bus.m_valid = 1'b0;
      bus.m_data  = '0;
      bus.m_last  = 1'b0;
      case (state)
         IDLE: begin
            idx_nxt = '0;
            if (!empty || push) begin
               state_nxt = SEND;
            end
         end
         SEND: begin
            bus.m_valid = 1'b1;
            bus.m_data  = block_word(head, idx);
            bus.m_last  = (idx == LAST_WORD_IDX);
            if (bus.m_ready) begin
               idx_nxt = idx + word_idx_t'(1);
               if (idx == LAST_WORD_IDX && level == LEVEL_W'(1) && !push) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_aes_out_serializer.sv
// Bench for aes_out_serializer: known-answer vectors, multi-cycle corner
// sequences and a randomized run against a queue-based reference model.
module tb_aes_out_serializer;
   import aes_pkg::*;

   localparam int LATENCY = 10;
   localparam int DEPTH   = 4;
   localparam int LEVEL_W = $clog2(DEPTH + 1);

   typedef struct {
      logic [127:0] key;
      logic [31:0]  w [4];
   } vec_t;

   logic               clk = 1'b0;
   logic               reset;
   logic               in_start;
   logic [127:0]       cryptokey_in;
   logic [LEVEL_W-1:0] level;
   logic               overflow;

   aes_out_serializer_if bus();

   aes_out_serializer #(
      .LATENCY    (LATENCY),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_start     (in_start),
      .cryptokey_in (cryptokey_in),
      .bus          (bus),
      .level        (level),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // Reference model: a queue of whole blocks, a word counter and the list
   // of cycles in which a block was started.
   logic [127:0] mq [$];
   int           mstarts [$];
   int           mwidx = 0;
   logic         movf = 1'b0;
   int           cyc = 0;

   logic               s_valid;
   logic [31:0]        s_data;
   logic               s_last;
   logic [LEVEL_W-1:0] s_level;
   logic               s_ovf;
   logic               s_acc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] ref_word(input logic [127:0] b, input int i);
      logic [127:0] t;
      t = b >> (32 * (3 - i));
      return t[31:0];
   endfunction

   function automatic logic [127:0] rk();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [127:0] okey(input int k);
      return {32'hC0DE0000 + 32'(4*k), 32'hC0DE0000 + 32'(4*k+1),
              32'hC0DE0000 + 32'(4*k+2), 32'hC0DE0000 + 32'(4*k+3)};
   endfunction

   // One clock cycle: drive inputs, compare outputs with the model, then
   // advance the model across the coming edge.
   task automatic cycle(input logic st, input logic [127:0] key, input logic rdy, input logic rs);
      logic               ev;
      logic [31:0]        ed;
      logic               el;
      logic [LEVEL_W-1:0] elev;
      logic               tap;
      logic               pop;
      reset        = rs;
      in_start     = st;
      cryptokey_in = key;
      bus.m_ready  = rdy;
      if (rs) begin
         mq.delete();
         mstarts.delete();
         mwidx = 0;
         movf  = 1'b0;
      end
      #1;
      ev   = (mq.size() > 0);
      ed   = ev ? ref_word(mq[0], mwidx) : 32'd0;
      el   = ev && (mwidx == 3);
      elev = LEVEL_W'(mq.size());
      s_valid = bus.m_valid;
      s_data  = bus.m_data;
      s_last  = bus.m_last;
      s_level = level;
      s_ovf   = overflow;
      s_acc   = bus.m_valid && rdy;
      check("model", 64'({s_valid, s_data, s_last, s_level, s_ovf}), 64'({ev, ed, el, elev, movf}));
      if (!rs) begin
         tap = (mstarts.size() > 0) && (mstarts[0] == cyc - LATENCY);
         if (tap) void'(mstarts.pop_front());
         pop = ev && rdy && (mwidx == 3);
         if (ev && rdy) mwidx = (mwidx + 1) % 4;
         if (pop) void'(mq.pop_front());
         if (tap) begin
            if (mq.size() < DEPTH) mq.push_back(key);
            else movf = 1'b1;
         end
         if (st) mstarts.push_back(cyc);
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   vec_t         vecs [4];
   logic [31:0]  alt_w [8];
   logic [127:0] alt [2];
   logic [31:0]  got [$];
   int           maxlev;
   int           first_v;
   int           last_v;
   int           nvalid;
   logic         rdy;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      vecs[0].key = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      vecs[0].w   = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
      vecs[1].key = 128'hff0b844a0853bf7c6934ab4364148fb9;
      vecs[1].w   = '{32'hff0b844a, 32'h0853bf7c, 32'h6934ab43, 32'h64148fb9};
      vecs[2].key = 128'h00112233445566778899aabbccddeeff;
      vecs[2].w   = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
      vecs[3].key = 128'h0123456789abcdeffedcba9876543210;
      vecs[3].w   = '{32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210};
      alt[0] = vecs[0].key;
      alt[1] = vecs[1].key;
      alt_w  = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a,
                 32'hff0b844a, 32'h0853bf7c, 32'h6934ab43, 32'h64148fb9};

      reset = 1'b1; in_start = 1'b0; cryptokey_in = '0; bus.m_ready = 1'b0;

      // Reset state
      cycle(1'b0, rk(), 1'b1, 1'b1);
      cycle(1'b1, rk(), 1'b1, 1'b1);
      check("rst_valid", 64'(s_valid), 64'(0));
      check("rst_data",  64'(s_data),  64'(0));
      check("rst_last",  64'(s_last),  64'(0));
      check("rst_level", 64'(s_level), 64'(0));
      check("rst_ovf",   64'(s_ovf),   64'(0));
      for (int i = 0; i < 12; i++) cycle(1'b0, rk(), 1'b1, 1'b0);
      check("rst_start_ignored", 64'(s_valid), 64'(0));

      // Known-answer blocks, ready held high
      for (int v = 0; v < 4; v++) begin
         cycle(1'b1, rk(), 1'b1, 1'b0);
         for (int i = 0; i < 9; i++) cycle(1'b0, rk(), 1'b1, 1'b0);
         cycle(1'b0, vecs[v].key, 1'b1, 1'b0);
         for (int k = 0; k < 4; k++) begin
            cycle(1'b0, rk(), 1'b1, 1'b0);
            check($sformatf("vec%0d_w%0d", v, k), 64'({s_valid, s_last, s_data}),
                  64'({1'b1, (k == 3), vecs[v].w[k]}));
         end
         cycle(1'b0, rk(), 1'b1, 1'b0);
         check($sformatf("vec%0d_idle", v), 64'(s_valid), 64'(0));
      end

      // Alternating blocks every 4 cycles: continuous stream
      got.delete(); maxlev = 0; first_v = -1; last_v = -1; nvalid = 0;
      for (int i = 0; i < 40; i++) begin
         cycle((i % 4 == 0) && (i < 24),
               (i >= LATENCY && (i - LATENCY) % 4 == 0 && (i - LATENCY) / 4 < 6) ? alt[((i - LATENCY) / 4) % 2] : rk(),
               1'b1, 1'b0);
         if (s_acc) got.push_back(s_data);
         if (s_valid) begin
            nvalid++;
            if (first_v < 0) first_v = i;
            last_v = i;
         end
         if (int'(s_level) > maxlev) maxlev = int'(s_level);
      end
      check("alt_words", 64'(got.size()), 64'(24));
      check("alt_contiguous", 64'(last_v - first_v + 1), 64'(nvalid));
      check("alt_maxlevel", 64'(maxlev), 64'(1));
      check("alt_ovf", 64'(s_ovf), 64'(0));
      for (int j = 0; j < got.size(); j++) check($sformatf("alt_w%0d", j), 64'(got[j]), 64'(alt_w[j % 8]));

      // Backpressure during word 1
      got.delete();
      cycle(1'b1, rk(), 1'b1, 1'b0);
      for (int i = 0; i < 9; i++) cycle(1'b0, rk(), 1'b1, 1'b0);
      cycle(1'b0, vecs[0].key, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         rdy = !(i >= 1 && i <= 3);
         cycle(1'b0, rk(), rdy, 1'b0);
         if (!rdy) check($sformatf("bp_hold%0d", i), 64'({s_valid, s_data}), 64'({1'b1, 32'h6a7b0430}));
         if (s_acc) got.push_back(s_data);
      end
      check("bp_count", 64'(got.size()), 64'(4));
      for (int j = 0; j < got.size() && j < 4; j++) check($sformatf("bp_w%0d", j), 64'(got[j]), 64'(vecs[0].w[j]));

      // Overflow: six results with the consumer stalled
      got.delete();
      for (int i = 0; i < 16; i++) begin
         cycle(i < 6, (i >= 10) ? okey(i - 10) : rk(), 1'b0, 1'b0);
         if (i == 14) check("ovf_before5", 64'({s_level, s_ovf}), 64'({3'd4, 1'b0}));
         if (i == 15) check("ovf_after5",  64'({s_level, s_ovf}), 64'({3'd4, 1'b1}));
      end
      for (int i = 0; i < 30; i++) begin
         cycle(1'b0, rk(), 1'b1, 1'b0);
         if (s_acc) got.push_back(s_data);
      end
      check("ovf_count", 64'(got.size()), 64'(16));
      for (int n = 0; n < got.size(); n++) check($sformatf("ovf_w%0d", n), 64'(got[n]), 64'(32'hC0DE0000 + 32'(n)));
      check("ovf_sticky", 64'({s_level, s_ovf}), 64'({3'd0, 1'b1}));

      cycle(1'b0, rk(), 1'b1, 1'b1);
      check("ovf_cleared", 64'(s_ovf), 64'(0));

      // Full FIFO with pop and push in the same cycle
      got.delete();
      for (int i = 0; i < 19; i++) begin
         cycle((i < 4) || (i == 7),
               (i >= 10 && i <= 13) ? okey(i - 10) : ((i == 17) ? okey(4) : rk()),
               i >= 14, 1'b0);
         if (s_acc) got.push_back(s_data);
         if (i == 14) check("pp_full", 64'(s_level), 64'(4));
         if (i == 18) check("pp_after", 64'({s_level, s_ovf}), 64'({3'd4, 1'b0}));
      end
      for (int i = 0; i < 30; i++) begin
         cycle(1'b0, rk(), 1'b1, 1'b0);
         if (s_acc) got.push_back(s_data);
      end
      check("pp_count", 64'(got.size()), 64'(20));
      for (int n = 0; n < got.size(); n++) check($sformatf("pp_w%0d", n), 64'(got[n]), 64'(32'hC0DE0000 + 32'(n)));

      // Reset during word 2 with two blocks buffered and three in flight
      for (int i = 0; i < 14; i++) begin
         cycle((i < 2) || (i >= 4 && i <= 6),
               (i == 10) ? vecs[0].key : ((i == 11) ? vecs[1].key : rk()),
               1'b1, i == 13);
         if (i == 12) check("rm_pre", 64'({s_valid, s_data, s_level}), 64'({1'b1, 32'h6a7b0430, 3'd2}));
         if (i == 13) check("rm_zero", 64'({s_valid, s_data, s_last, s_level, s_ovf}), 64'(0));
      end
      nvalid = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, rk(), 1'b1, 1'b0);
         if (s_valid) nvalid++;
      end
      check("rm_silent", 64'(nvalid), 64'(0));
      first_v = -1;
      cycle(1'b1, rk(), 1'b1, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         cycle(1'b0, (i == LATENCY) ? vecs[1].key : rk(), 1'b1, 1'b0);
         if (s_valid && first_v < 0) begin
            first_v = i;
            check("rm_fresh_w0", 64'(s_data), 64'(32'hff0b844a));
         end
      end
      check("rm_fresh_latency", 64'(first_v), 64'(LATENCY + 1));

      // Randomized traffic with occasional resets
      for (int i = 0; i < 900; i++) begin
         cycle((i < 450) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0),
               rk(), $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
      end
      for (int i = 0; i < 40; i++) cycle(1'b0, rk(), 1'b1, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
